fetch_queue: RTL

//  Instruction queue between the fetch stage and decode. Holds {pc, instruction} pairs produced by fetch.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue holding {pc, instruction} pairs.
// Optional zero-latency empty bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int          DEPTH_LOG2 = 2,
   parameter logic [31:0] RESET_PC   = 32'h01000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [31:0]           in_pc,
   input  logic [31:0]           in_instruction,
   input  logic                  flush,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [31:0]           out_pc,
   output logic [31:0]           out_instruction,
   output logic                  stall,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [31:0] NOP = 32'h00000013;

   logic [31:0]           r_mem_pc [DEPTH];
   logic [31:0]           r_mem_ins [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [31:0]           r_last_pc;
   logic [31:0]           r_last_ins;

   logic w_empty;
   logic w_full;
   logic w_take;
   logic w_push;
   logic w_pop;

   // Handshake decode; flush overrides both push and pop
   always_comb begin
      w_empty = (r_count == '0);
      w_full  = (r_count == FULL);
`ifdef FETCH_QUEUE_BYPASS_EN
      w_take  = w_empty && in_valid && !flush && out_ready;
`else
      w_take  = 1'b0;
`endif
      w_push  = in_valid && !w_full && !flush && !w_take;
      w_pop   = !w_empty && out_ready && !flush;
   end

   // Head entry view; empty queue shows the last consumed entry
   always_comb begin
      out_valid       = !w_empty;
      out_pc          = w_empty ? r_last_pc  : r_mem_pc[r_rd_ptr];
      out_instruction = w_empty ? r_last_ins : r_mem_ins[r_rd_ptr];
`ifdef FETCH_QUEUE_BYPASS_EN
      if (w_empty && in_valid && !flush) begin
         out_valid       = 1'b1;
         out_pc          = in_pc;
         out_instruction = in_instruction;
      end
`endif
      stall = w_full;
      count = r_count;
   end

   // Entry storage; contents need no reset
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]  <= in_pc;
         r_mem_ins[r_wr_ptr] <= in_instruction;
      end
   end

   // Pointer and occupancy state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + ONE;
            2'b01:   r_count <= r_count - ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Remember the most recently consumed entry for the empty view
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_last_pc  <= RESET_PC;
         r_last_ins <= NOP;
      end else if (w_pop) begin
         r_last_pc  <= r_mem_pc[r_rd_ptr];
         r_last_ins <= r_mem_ins[r_rd_ptr];
      end else if (w_take) begin
         r_last_pc  <= in_pc;
         r_last_ins <= in_instruction;
      end
   end

endmodule
